flit_sink_checker: RTL and testbench
====================================

# flit_sink_checker

Receive-side endpoint for the NoC traffic tests: consumes the 20-bit flit stream delivered by a router output port, checks each flit's destination and per-source sequence number, and keeps registered pass/fail statistics. One instance sits at each node's ejection port, mirroring the per-node injection buffers at the ingress side.

## Interface
- NODE_ID, 4'd3: this node's address; a flit's dest field must equal it
- EXPECTED_COUNT, 30: flits that complete a run
- TIMEOUT_CYCLES, 256: idle cycles after the first flit before the run is declared stalled
- clk  input  1  clock; all logic on posedge
- rst  input  1  asynchronous, active-high reset
- datain  input  20  received flit
- in_valid  input  1  datain valid this cycle; no backpressure, every valid flit is consumed
- rx_count  output  16  valid flits received
- err_count  output  16  flits with any error
- dest_err  output  1  sticky: a flit arrived with dest != NODE_ID
- seq_err  output  1  sticky: a sequence gap or repeat was seen
- err_pulse  output  1  one-cycle pulse for each erroneous flit
- last_flit  output  20  most recent valid flit
- done  output  1  sticky: rx_count reached EXPECTED_COUNT
- stalled  output  1  sticky: TIMEOUT_CYCLES idle cycles elapsed in RECV

## Operation
- Flit fields: [19:16] type (reserved, ignored), [15:12] source node, [11:4] sequence, [3:0] destination ([3:2] cluster, [1:0] local).
- FSM states: IDLE, RECV, DONE, STALL.
  - IDLE: no flit received yet. A valid flit moves the FSM to RECV.
  - RECV: accepts flits. Moves to DONE when the flit that makes rx_count == EXPECTED_COUNT is accepted. Moves to STALL when the idle counter reaches TIMEOUT_CYCLES.
  - DONE: further valid flits are still counted and checked; done stays 1.
  - STALL: a valid flit returns the FSM to RECV and clears the idle counter; stalled stays 1.
- Idle counter:
  - 16-bit, cleared by every valid flit, increments in RECV only, saturates.
- Destination check:
  - datain[3:0] != NODE_ID sets dest_err and counts the flit as an error.
- Sequence check (per source, 16 entries of 8 bits plus a seen bit):
  - First flit from a source: sequence must be 8'h01.
  - Later flits from that source: sequence must equal the previous sequence + 1, mod 256 (8'hFF -> 8'h00 is legal).
  - On a mismatch, set seq_err and resync the expected value to received + 1.
- A flit with both errors increments err_count once and produces one err_pulse.
- Counters saturate at 16'hFFFF.

## Timing
- All outputs are registered.
- A flit sampled at edge N updates rx_count, err_count, last_flit, the sticky flags and the FSM state on edge N. These are visible in the cycle after N; err_pulse is high for that cycle only.
- Back-to-back valid flits every cycle are supported, with no bubbles.
- Same source on consecutive cycles: the check at edge N+1 uses the table entry written at edge N (internal bypass is required).
- Reset values: all counters 0, last_flit 20'h00000, every flag 0, FSM IDLE, sequence table cleared (all seen bits 0). Reset mid-run aborts immediately.

## Configuration
- FLIT_SINK_SEQ_CHECK_EN defined: per-source sequence table and seq_err logic are present.
- Not defined: the table is removed, seq_err is tied to 0, and only destination errors count toward err_count and err_pulse.

## Structure
- Package noc_flit_pkg holds:
  - field positions and widths (FLIT_W=20, SRC_LSB=12, SEQ_LSB=4, DEST_LSB=0)
  - the flit struct/typedef
  - the FSM state enum
- Sub-module seq_tracker contains the 16-entry table, the bypass, and the mismatch output. It is instantiated only under FLIT_SINK_SEQ_CHECK_EN.

## Test plan
- Clean run: 30 flits 20'h01013..20'h011E3 (source 1, seq 1..30, dest 3), one per cycle. Required: rx_count=30, err_count=0, done=1 in the cycle after the 30th flit, last_flit=20'h011E3.
- Destination error: flit 20'h01012 mid-stream. Required: dest_err=1, one err_pulse, err_count=1, rx_count still increments.
- Sequence gap: seq 1,2,4 from source 1. Required: seq_err=1 at the third flit. A following seq 5 is accepted with no new error.
- Interleaved sources with wrap: source 1 runs seq 8'hFE,8'hFF,8'h00 (after a valid ramp from 1) alternating every cycle with source 2 seq 1,2,3. Required: no errors.
- Timeout: 1 flit, then 256 idle cycles. Required: stalled=1. A next valid flit returns the FSM to RECV and stalled stays 1.
- Reset mid-run: assert rst after 10 flits. Required: all outputs 0 immediately. A replay of seq 1.. from source 1 produces no seq_err.

Source files
------------

// File: rtl/noc_flit_pkg.sv
// Shared flit field layout, flit struct and sink FSM state encoding for the
// NoC traffic-test endpoints.
package noc_flit_pkg;

   localparam int FLIT_W   = 20;
   localparam int SRC_LSB  = 12;
   localparam int SEQ_LSB  = 4;
   localparam int DEST_LSB = 0;
   localparam int SRC_W    = 4;
   localparam int SEQ_W    = 8;
   localparam int DEST_W   = 4;

   typedef struct packed {
      logic [3:0]       ftype;
      logic [SRC_W-1:0] src;
      logic [SEQ_W-1:0] seq;
      logic [DEST_W-1:0] dest;
   } flit_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_DONE,
      ST_STALL
   } state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/seq_tracker.sv
// Per-source sequence tracker: 16 entries of expected-next sequence plus a
// seen bit; flags a gap or repeat and resyncs to received + 1.
module seq_tracker
   import noc_flit_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [SRC_W-1:0] src,
   input  logic [SEQ_W-1:0] seq,
   output logic             mismatch
);

   logic [SEQ_W-1:0] expect_seq [16];
   logic [15:0]      seen;
   logic [SEQ_W-1:0] want;

   // Read is combinational, so an entry written at edge N is already the
   // value checked at edge N+1: back-to-back flits from one source bypass.
   always_comb begin
      want = seen[src] ? expect_seq[src] : 8'h01;
   end

   assign mismatch = in_valid && (seq != want);

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_entry
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               seen[gi]       <= 1'b0;
               expect_seq[gi] <= '0;
            end else if (in_valid && (src == SRC_W'(gi))) begin
               seen[gi]       <= 1'b1;
               expect_seq[gi] <= seq + 8'd1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/flit_sink_checker.sv
// Ejection-port flit sink: counts flits, checks destination and (with
// FLIT_SINK_SEQ_CHECK_EN defined) per-source sequence, tracks done/stall.
module flit_sink_checker
   import noc_flit_pkg::*;
#(
   parameter logic [3:0] NODE_ID        = 4'd3,
   parameter int         EXPECTED_COUNT = 30,
   parameter int         TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLIT_W-1:0] datain,
   input  logic              in_valid,
   output logic [15:0]       rx_count,
   output logic [15:0]       err_count,
   output logic              dest_err,
   output logic              seq_err,
   output logic              err_pulse,
   output logic [FLIT_W-1:0] last_flit,
   output logic              done,
   output logic              stalled
);

   localparam logic [15:0] EXP_CNT  = 16'(EXPECTED_COUNT);
   localparam logic [15:0] TIMEOUT  = 16'(TIMEOUT_CYCLES);

   flit_t       flit;
   state_t      state;
   logic [15:0] idle_cnt;
   logic [15:0] rx_next;
   logic [15:0] idle_next;
   logic        dest_bad;
   logic        seq_bad;
   logic        flit_err;

   assign flit      = datain;
   assign dest_bad  = (flit.dest != NODE_ID);
   assign rx_next   = sat_inc(rx_count);
   assign idle_next = sat_inc(idle_cnt);

`ifdef FLIT_SINK_SEQ_CHECK_EN
   seq_tracker u_seq_tracker (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .src      (flit.src),
      .seq      (flit.seq),
      .mismatch (seq_bad)
   );
`else
   assign seq_bad = 1'b0;
`endif

   // A flit carrying both errors still counts as one erroneous flit.
   assign flit_err = dest_bad | seq_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         idle_cnt  <= '0;
         rx_count  <= '0;
         err_count <= '0;
         dest_err  <= 1'b0;
         seq_err   <= 1'b0;
         err_pulse <= 1'b0;
         last_flit <= '0;
         done      <= 1'b0;
         stalled   <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         if (in_valid) begin
            rx_count  <= rx_next;
            last_flit <= flit;
            idle_cnt  <= '0;
            if (flit_err) begin
               err_count <= sat_inc(err_count);
               err_pulse <= 1'b1;
            end
            if (dest_bad) dest_err <= 1'b1;
            if (seq_bad)  seq_err  <= 1'b1;
            if (rx_next == EXP_CNT) begin
               done  <= 1'b1;
               state <= ST_DONE;
            end else if (state != ST_DONE) begin
               state <= ST_RECV;
            end
         end else if (state == ST_RECV) begin
            idle_cnt <= idle_next;
            if (idle_next == TIMEOUT) begin
               stalled <= 1'b1;
               state   <= ST_STALL;
            end
         end
      end
   end

endmodule

// File: tb/tb_flit_sink_checker.sv
// Bench for flit_sink_checker: directed flit streams, a spec-level model
// compared every cycle, and hand-computed literal expectations per scenario.
module tb_flit_sink_checker;

`ifdef FLIT_SINK_SEQ_CHECK_EN
   localparam bit SEQ_EN = 1'b1;
`else
   localparam bit SEQ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] datain;
   logic        in_valid;
   logic [15:0] rx_count;
   logic [15:0] err_count;
   logic        dest_err;
   logic        seq_err;
   logic        err_pulse;
   logic [19:0] last_flit;
   logic        done;
   logic        stalled;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   bit cmp_on = 1'b0;

   flit_sink_checker dut (
      .clk       (clk),
      .rst       (rst),
      .datain    (datain),
      .in_valid  (in_valid),
      .rx_count  (rx_count),
      .err_count (err_count),
      .dest_err  (dest_err),
      .seq_err   (seq_err),
      .err_pulse (err_pulse),
      .last_flit (last_flit),
      .done      (done),
      .stalled   (stalled)
   );

   always #5 clk = ~clk;

   // Model: counts, sticky flags, last flit, per-source last sequence and a
   // run phase (0 not started, 1 receiving, 2 complete, 3 stalled).
   int          m_rx, m_err, m_idle, m_phase;
   bit          m_dest, m_seq, m_pulse, m_done, m_stall;
   logic [19:0] m_last;
   bit          m_seen [16];
   int          m_prev [16];

   function automatic bit model_seq_bad(input logic [19:0] f);
      int s;
      int q;
      s = int'(f[15:12]);
      q = int'(f[11:4]);
      if (!SEQ_EN) return 1'b0;
      if (!m_seen[s]) return q != 1;
      return q != ((m_prev[s] + 1) % 256);
   endfunction

   function automatic bit model_dest_bad(input logic [19:0] f);
      return f[3:0] != 4'd3;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rx <= 0; m_err <= 0; m_idle <= 0; m_phase <= 0;
         m_dest <= 0; m_seq <= 0; m_pulse <= 0; m_done <= 0; m_stall <= 0;
         m_last <= '0;
         for (int i = 0; i < 16; i++) begin
            m_seen[i] <= 1'b0;
            m_prev[i] <= 0;
         end
      end else begin
         m_pulse <= 1'b0;
         if (in_valid) begin
            m_rx   <= (m_rx >= 65535) ? 65535 : m_rx + 1;
            m_last <= datain;
            m_idle <= 0;
            if (model_dest_bad(datain) || model_seq_bad(datain)) begin
               m_err   <= (m_err >= 65535) ? 65535 : m_err + 1;
               m_pulse <= 1'b1;
            end
            if (model_dest_bad(datain)) m_dest <= 1'b1;
            if (model_seq_bad(datain))  m_seq  <= 1'b1;
            m_seen[datain[15:12]] <= 1'b1;
            m_prev[datain[15:12]] <= int'(datain[11:4]);
            if (m_rx + 1 == 30) begin
               m_done  <= 1'b1;
               m_phase <= 2;
            end else if (m_phase != 2) begin
               m_phase <= 1;
            end
         end else if (m_phase == 1) begin
            m_idle <= (m_idle >= 65535) ? 65535 : m_idle + 1;
            if (m_idle + 1 == 256) begin
               m_stall <= 1'b1;
               m_phase <= 3;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("cyc_rx_count",  32'(rx_count),  32'(m_rx));
         chk("cyc_err_count", 32'(err_count), 32'(m_err));
         chk("cyc_dest_err",  32'(dest_err),  32'(m_dest));
         chk("cyc_seq_err",   32'(seq_err),   32'(m_seq));
         chk("cyc_err_pulse", 32'(err_pulse), 32'(m_pulse));
         chk("cyc_last_flit", 32'(last_flit), 32'(m_last));
         chk("cyc_done",      32'(done),      32'(m_done));
         chk("cyc_stalled",   32'(stalled),   32'(m_stall));
      end
      if (err_pulse) pulses++;
   end

   task automatic send(input logic [19:0] f);
      @(posedge clk); #1;
      datain   = f;
      in_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         datain   = '0;
      end
   endtask

   task automatic look();
      idle(1);
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      datain   = '0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   function automatic logic [19:0] mk(input int src, input int seq, input int dest);
      return {4'h0, 4'(src), 8'(seq), 4'(dest)};
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; datain = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rx_count",  32'(rx_count),  32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_last_flit", 32'(last_flit), 32'd0);
      chk("rst_flags", 32'({dest_err, seq_err, err_pulse, done, stalled}), 32'd0);
      rst = 1'b0;
      cmp_on = 1'b1;

      // Clean run of 30 flits from source 1.
      for (int i = 1; i <= 30; i++) send(mk(1, i, 3));
      look();
      chk("clean_rx_count",  32'(rx_count),  32'd30);
      chk("clean_err_count", 32'(err_count), 32'd0);
      chk("clean_done",      32'(done),      32'd1);
      chk("clean_last_flit", 32'(last_flit), 32'h011E3);

      // Destination error mid-stream.
      do_reset();
      pulses = 0;
      send(20'h02013); send(20'h02023); send(20'h01012); send(20'h01023);
      look();
      chk("dest_dest_err",  32'(dest_err),  32'd1);
      chk("dest_err_count", 32'(err_count), 32'd1);
      chk("dest_rx_count",  32'(rx_count),  32'd4);
      chk("dest_pulses",    32'(pulses),    32'd1);

      // Sequence gap 1,2,4 then 5.
      do_reset();
      send(20'h01013); send(20'h01023); send(20'h01043);
      look();
      chk("gap_seq_err",   32'(seq_err),   32'(SEQ_EN));
      chk("gap_err_count", 32'(err_count), SEQ_EN ? 32'd1 : 32'd0);
      send(20'h01053);
      look();
      chk("gap_resync_err_count", 32'(err_count), SEQ_EN ? 32'd1 : 32'd0);
      chk("gap_rx_count",         32'(rx_count),  32'd4);

      // Source 1 ramps to FD, then wraps FE,FF,00 interleaved with source 2.
      do_reset();
      for (int i = 1; i <= 253; i++) send(mk(1, i, 3));
      for (int k = 0; k < 3; k++) begin
         send(mk(1, (254 + k) % 256, 3));
         send(mk(2, k + 1, 3));
      end
      look();
      chk("wrap_err_count", 32'(err_count), 32'd0);
      chk("wrap_seq_err",   32'(seq_err),   32'd0);
      chk("wrap_rx_count",  32'(rx_count),  32'd259);
      chk("wrap_last_flit", 32'(last_flit), 32'h02033);

      // Timeout: one flit, then exactly 255 and 256 idle cycles.
      do_reset();
      send(20'h01013);
      idle(256);
      @(negedge clk); #1;
      chk("to_255_stalled", 32'(stalled), 32'd0);
      idle(1);
      @(negedge clk); #1;
      chk("to_256_stalled", 32'(stalled), 32'd1);
      send(20'h01023);
      look();
      chk("to_resume_stalled",  32'(stalled),  32'd1);
      chk("to_resume_rx_count", 32'(rx_count), 32'd2);

      // Reset mid-run, then replay from seq 1.
      do_reset();
      for (int i = 1; i <= 10; i++) send(mk(1, i, 3));
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b0; datain = '0;
      #1;
      chk("mid_rx_count",  32'(rx_count),  32'd0);
      chk("mid_err_count", 32'(err_count), 32'd0);
      chk("mid_last_flit", 32'(last_flit), 32'd0);
      chk("mid_flags", 32'({dest_err, seq_err, err_pulse, done, stalled}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 1; i <= 5; i++) send(mk(1, i, 3));
      look();
      chk("replay_seq_err",   32'(seq_err),   32'd0);
      chk("replay_err_count", 32'(err_count), 32'd0);
      chk("replay_rx_count",  32'(rx_count),  32'd5);

      cmp_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
